rr_mux_n: RTL and testbench

- Parametrised successor to the 2-input datapath mux: N-input, WIDTH-bit selector with per-channel valid/ready handshake and round-robin arbitration.
- Selection is driven by requester activity instead of an external select line.
- Has a single registered output stage, one entry deep.
- Used where several pipeline sources share one consumer, e.g. fetch/data requests onto one memory port or multiple result sources onto a writeback bus.

---
 rtl/rr_mux_n.sv | 88 ++++++++
 tb/tb_rr_mux_n.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_n.sv
// N-input valid/ready selector with round-robin arbitration and one registered output stage.
// Define RR_MUX_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module rr_mux_n #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    logic            load;
    logic            transfer;
    logic [SELW-1:0] base;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic [SELW-1:0] next_ptr;

    assign load     = !out_valid || out_ready;
    assign transfer = |in_ready;
    assign next_ptr = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;

`ifdef RR_MUX_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [SELW-1:0] ptr;

    // The pointer only advances on a real transfer, so a stalled output never skips a channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= next_ptr;
        end
    end

    assign base = ptr;
`endif

    // Circular search starting at base; indices are folded back below N so no out-of-range grant exists.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(base) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid && in_valid[idx]) begin
                grant       = SELW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && grant_valid && !rst) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
                out_sel   <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed self-checking bench for rr_mux_n: a 4-channel and a 3-channel instance share clk/rst.
// Expectations follow round-robin unless RR_MUX_FIXED_PRIO_EN is defined.
module tb_rr_mux_n;

    logic         clk;
    logic         rst;

    logic [127:0] in_data4;
    logic [3:0]   in_valid4;
    logic [3:0]   in_ready4;
    logic [31:0]  out_data4;
    logic         out_valid4;
    logic         out_ready4;
    logic [1:0]   out_sel4;

    logic [23:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [7:0]   out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [1:0]   out_sel3;

    int passed;
    int total;

    rr_mux_n #(.WIDTH(32), .N(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sel(out_sel4)
    );

    rr_mux_n #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_sel(out_sel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        in_valid4  = valid;
        out_ready4 = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst        = 1'b1;
        in_data4   = '0;
        in_data3   = '0;
        in_valid3  = '0;
        out_ready3 = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("reset_out_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("reset_out_data", out_data4, 32'd0);
        checkOutput("reset_out_sel", {30'd0, out_sel4}, 32'd0);
        checkOutput("reset_in_ready", {28'd0, in_ready4}, 32'd0);

        // Single channel
        rst = 1'b0;
        in_data4[31:0] = 32'hAAAA_AAAA;
        applyStimulus(4'b0001, 1'b1);
        checkOutput("single_in_ready", {28'd0, in_ready4}, 32'h1);
        tick();
        checkOutput("single_out_valid", {31'd0, out_valid4}, 32'd1);
        checkOutput("single_out_data", out_data4, 32'hAAAA_AAAA);
        checkOutput("single_out_sel", {30'd0, out_sel4}, 32'd0);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("single_idle_in_ready", {28'd0, in_ready4}, 32'd0);
        tick();
        checkOutput("single_drain_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("single_drain_data_hold", out_data4, 32'hAAAA_AAAA);

        // All channels valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data4 = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("rr_out_valid", {31'd0, out_valid4}, 32'd1);
`ifdef RR_MUX_FIXED_PRIO_EN
            checkOutput("rr_out_sel", {30'd0, out_sel4}, 32'd0);
            checkOutput("rr_out_data", out_data4, 32'd0);
`else
            checkOutput("rr_out_sel", {30'd0, out_sel4}, k % 4);
            checkOutput("rr_out_data", out_data4, k % 4);
`endif
        end

        // Backpressure
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data4 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("bp_first_sel", {30'd0, out_sel4}, 32'd0);
        checkOutput("bp_first_data", out_data4, 32'h1234_5678);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("bp_in_ready_stalled", {28'd0, in_ready4}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_hold_valid", {31'd0, out_valid4}, 32'd1);
            checkOutput("bp_hold_data", out_data4, 32'h1234_5678);
            checkOutput("bp_hold_sel", {30'd0, out_sel4}, 32'd0);
            checkOutput("bp_hold_in_ready", {28'd0, in_ready4}, 32'd0);
        end
        applyStimulus(4'b1111, 1'b1);
`ifdef RR_MUX_FIXED_PRIO_EN
        checkOutput("bp_release_in_ready", {28'd0, in_ready4}, 32'h1);
        tick();
        checkOutput("bp_release_sel", {30'd0, out_sel4}, 32'd0);
        checkOutput("bp_release_data", out_data4, 32'h1234_5678);
        applyStimulus(4'b1110, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("fixed_drop0_sel", {30'd0, out_sel4}, 32'd1);
            checkOutput("fixed_drop0_data", out_data4, 32'h1111_1111);
        end
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("fixed_back0_sel", {30'd0, out_sel4}, 32'd0);
`else
        checkOutput("bp_release_in_ready", {28'd0, in_ready4}, 32'h2);
        tick();
        checkOutput("bp_release_sel", {30'd0, out_sel4}, 32'd1);
        checkOutput("bp_release_data", out_data4, 32'h1111_1111);
        tick();
        checkOutput("pre_reset_sel", {30'd0, out_sel4}, 32'd2);
        checkOutput("pre_reset_valid", {31'd0, out_valid4}, 32'd1);
`endif

        // Reset mid-operation with a held beat
        rst = 1'b1;
        tick();
        checkOutput("midrst_out_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("midrst_out_data", out_data4, 32'd0);
        checkOutput("midrst_out_sel", {30'd0, out_sel4}, 32'd0);
        checkOutput("midrst_in_ready", {28'd0, in_ready4}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("postrst_in_ready", {28'd0, in_ready4}, 32'h1);
        tick();
        checkOutput("postrst_sel", {30'd0, out_sel4}, 32'd0);
        checkOutput("postrst_data", out_data4, 32'h1234_5678);

        // Three channels, channels 0 and 2 requesting
        applyStimulus(4'b0000, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data3  = {8'hA2, 8'hA1, 8'hA0};
        in_valid3 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("n3_out_valid", {31'd0, out_valid3}, 32'd1);
`ifdef RR_MUX_FIXED_PRIO_EN
            checkOutput("n3_out_sel", {30'd0, out_sel3}, 32'd0);
            checkOutput("n3_out_data", {24'd0, out_data3}, 32'hA0);
`else
            checkOutput("n3_out_sel", {30'd0, out_sel3}, (k % 2 == 0) ? 32'd0 : 32'd2);
            checkOutput("n3_out_data", {24'd0, out_data3}, (k % 2 == 0) ? 32'hA0 : 32'hA2);
`endif
        end
        in_valid3 = 3'b000;
        tick();
        checkOutput("n3_drain_valid", {31'd0, out_valid3}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
